// File: rtl/ex_operand_stage.sv
// Operand pipeline register between RegFile read and execute: captures operands and
// decoded control, bypasses same-cycle writeback, and inserts one bubble on load-use.
module ex_operand_stage #(
    parameter int W   = 8,
    parameter int D   = 4,
    parameter int OPW = 4
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           InValid,
    input  logic [OPW-1:0] InOp,
    input  logic           InIsLoad,
    input  logic           InUsesA,
    input  logic           InUsesB,
    input  logic [D-1:0]   RaddrA,
    input  logic [D-1:0]   RaddrB,
    input  logic [W-1:0]   DataA,
    input  logic [W-1:0]   DataB,
    input  logic [D-1:0]   InDst,
    input  logic           InDstWrEn,
    input  logic           WbWriteEn,
    input  logic [D-1:0]   WbWaddr,
    input  logic [W-1:0]   WbData,
    input  logic           StallIn,
    input  logic           Flush,
    output logic           HazardStall,
    output logic           OutValid,
    output logic [OPW-1:0] OutOp,
    output logic           OutIsLoad,
    output logic [W-1:0]   OpA,
    output logic [W-1:0]   OpB,
    output logic [D-1:0]   OutDst,
    output logic           OutDstWrEn,
    output logic [7:0]     BubbleCount
);

    // Handshake: an instruction offered with InValid=1 is taken at the posedge unless
    // Flush, StallIn or HazardStall is high; under StallIn/HazardStall decode must hold it.
    logic           r_valid;
    logic [OPW-1:0] r_op;
    logic           r_is_load;
    logic [W-1:0]   r_op_a;
    logic [W-1:0]   r_op_b;
    logic [D-1:0]   r_dst;
    logic           r_dst_wr_en;
    logic [7:0]     r_bubble_count;

    logic           w_fwd_a;
    logic           w_fwd_b;
    logic           w_hazard;
    logic [W-1:0]   w_op_a_next;
    logic [W-1:0]   w_op_b_next;

    // r0 is writable in this RegFile, so address 0 is bypassed like any other.
    assign w_fwd_a     = WbWriteEn && (WbWaddr == RaddrA);
    assign w_fwd_b     = WbWriteEn && (WbWaddr == RaddrB);
    assign w_op_a_next = w_fwd_a ? WbData : DataA;
    assign w_op_b_next = w_fwd_b ? WbData : DataB;

    assign w_hazard = r_valid && r_is_load && r_dst_wr_en && InValid &&
                      ((InUsesA && (r_dst == RaddrA)) || (InUsesB && (r_dst == RaddrB)));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_valid        <= 1'b0;
            r_op           <= '0;
            r_is_load      <= 1'b0;
            r_op_a         <= '0;
            r_op_b         <= '0;
            r_dst          <= '0;
            r_dst_wr_en    <= 1'b0;
            r_bubble_count <= 8'd0;
        end else if (Flush) begin
            r_valid     <= 1'b0;
            r_dst_wr_en <= 1'b0;
        end else if (StallIn) begin
            r_valid <= r_valid;
        end else if (w_hazard) begin
            // The bubble gives the load's writeback a cycle to reach WbData.
            r_valid     <= 1'b0;
            r_dst_wr_en <= 1'b0;
            r_is_load   <= 1'b0;
            if (r_bubble_count != 8'hFF) begin
                r_bubble_count <= r_bubble_count + 8'd1;
            end
        end else begin
            r_valid     <= InValid;
            r_op        <= InOp;
            r_is_load   <= InIsLoad;
            r_op_a      <= w_op_a_next;
            r_op_b      <= w_op_b_next;
            r_dst       <= InDst;
            r_dst_wr_en <= InDstWrEn && InValid;
        end
    end

    assign HazardStall = w_hazard;
    assign OutValid    = r_valid;
    assign OutOp       = r_op;
    assign OutIsLoad   = r_is_load;
    assign OpA         = r_op_a;
    assign OpB         = r_op_b;
    assign OutDst      = r_dst;
    assign OutDstWrEn  = r_dst_wr_en;
    assign BubbleCount = r_bubble_count;

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- Pipeline register between RegFile read and the ALU/execute stage of the 8-bit custom-ISA core.
- Captures the two RegFile read operands plus decoded control for one instruction per cycle.
- Bypasses same-cycle writeback data around the RegFile write latency.
- Detects load-use hazards, inserts one bubble, and counts bubbles for debug.

Parameters:
W, 8, data path width
D, 4, register address width (2**D registers)
OPW, 4, decoded ALU opcode width

Ports:
Clk  input  1  clock, all state updates on posedge
Reset  input  1  asynchronous, active-high; clears all state immediately
InValid  input  1  decode stage presents a valid instruction
InOp  input  OPW  decoded ALU opcode
InIsLoad  input  1  instruction is a data-memory load
InUsesA  input  1  instruction reads RaddrA
InUsesB  input  1  instruction reads RaddrB
RaddrA  input  D  source A address (same value driven to RegFile RaddrA)
RaddrB  input  D  source B address
DataA  input  W  RegFile DataOutA
DataB  input  W  RegFile DataOutB
InDst  input  D  destination register
InDstWrEn  input  1  instruction writes InDst
WbWriteEn  input  1  writeback port enable (same signal as RegFile WriteEn)
WbWaddr  input  D  writeback address
WbData  input  W  writeback data
StallIn  input  1  downstream stall: hold all stage contents
Flush  input  1  branch/jump flush: kill stage contents
HazardStall  output  1  combinational; upstream must hold PC/decode this cycle
OutValid  output  1  stage holds a live instruction
OutOp  output  OPW  registered opcode
OutIsLoad  output  1  registered load flag
OpA  output  W  registered operand A
OpB  output  W  registered operand B
OutDst  output  D  registered destination
OutDstWrEn  output  1  registered destination write enable
BubbleCount  output  8  saturating count of inserted hazard bubbles

Behaviour:
- Reset (async, active-high): OutValid=0, OutOp=0, OutIsLoad=0, OpA=0, OpB=0, OutDst=0, OutDstWrEn=0, BubbleCount=0. HazardStall evaluates to 0 because OutValid=0. Reset asserted mid-operation discards the held instruction with no partial state.
- Latency: one cycle. Inputs are sampled at posedge N and visible on the outputs after posedge N.
- Bypass: fwdA = WbWriteEn && WbWaddr==RaddrA. When fwdA is set, WbData is captured into OpA; otherwise DataA is captured. OpB uses the same rule with RaddrB.
- Bypass applies to every address, including r0, because RegFile r0 is writable.
- Bypass is applied to operand A even when InUsesA=0 (harmless). Operand B follows the same rule.
- HazardStall = OutValid && OutIsLoad && OutDstWrEn && InValid && ((InUsesA && OutDst==RaddrA) || (InUsesB && OutDst==RaddrB)). It is purely combinational.
- Update priority at each posedge, highest first:
  1. Flush: OutValid<=0 and OutDstWrEn<=0. Other fields are don't-care and hold. Flush wins over StallIn and hazard.
  2. StallIn: all registers hold. HazardStall still reflects the held contents. BubbleCount does not change.
  3. HazardStall: insert a bubble with OutValid<=0 and OutDstWrEn<=0, and BubbleCount increments, saturating at 255. Next cycle OutIsLoad=0, so the hazard clears and the held instruction is accepted.
  4. Otherwise load: OutValid<=InValid, OutDstWrEn<=InDstWrEn&&InValid, and all data/control fields <= inputs.
- A bubble caused by InValid=0 is not counted.
- Simultaneous hazard and forwarding: the bubble cycle lets the load's writeback reach WbData, so the next accept forwards it correctly. No extra logic is needed.
- OutDstWrEn is never 1 while OutValid is 0.

Test Plan:
- Reset then plain load: RaddrA=3, DataA=8'h3F, RaddrB=4, DataB=8'h40, InValid=1, InOp=4'h2. Next cycle: OpA=8'h3F, OpB=8'h40, OutOp=4'h2, OutValid=1, HazardStall=0.
- Forward: RaddrA=5, DataA=8'hFF, WbWriteEn=1, WbWaddr=5, WbData=8'h20. Next cycle OpA=8'h20. Repeat with WbWaddr=6 and expect OpA=8'hFF. Also forward on RaddrB=0 with WbWaddr=0, WbData=8'h11, and expect OpB=8'h11.
- Load-use: load with InDst=7 is accepted; next instruction has InUsesA=1, RaddrA=7. Expect HazardStall=1 for one cycle, then OutValid=0 (bubble), BubbleCount=1. On the following cycle the instruction is accepted with OpA=WbData.
- StallIn held 3 cycles with OpA=8'h55: outputs stay constant and BubbleCount is unchanged. Asserting Flush while StallIn=1 gives OutValid=0 and OutDstWrEn=0 next cycle.
- Async reset pulsed mid-cycle while OutValid=1 and BubbleCount=9: all outputs go to 0 before the next posedge.
- Saturation: force 260 load-use hazards. BubbleCount must read 255, not wrap to 4.
